// File: rtl/keypad_operand_entry.sv
// Keypad front end: folds decimal key codes into two saturating binary operands plus an opcode,
// then offers {A, B, OP} downstream. Optional backspace key enabled by KEYPAD_BACKSPACE_EN.
module keypad_operand_entry #(
    parameter int DIGITS  = 2,
    parameter int MAX_VAL = 99,
    parameter int W       = 7
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         iKEY_VALID,
    input  logic [4:0]   iKEY_CODE,
    output logic         oKEY_READY,
    output logic [W-1:0] oA,
    output logic [W-1:0] oB,
    output logic [1:0]   oOP,
    output logic         oVALID,
    input  logic         iRES_READY,
    output logic [1:0]   oSTATE,
    output logic         oERR
);

    localparam int CW = (DIGITS < 1) ? 1 : $clog2(DIGITS + 1);
    localparam logic [W+3:0] TEN_WIDE = (W + 4)'(10);
    localparam logic [W+3:0] MAX_WIDE = (W + 4)'(MAX_VAL);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OUT = 2'b10
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [1:0]    r_op;
    logic [CW-1:0] r_cnt_a;
    logic [CW-1:0] r_cnt_b;
    logic          r_valid;
    logic          r_err;

    logic          w_key_fire;
    logic          w_is_digit;
    logic          w_is_oper;
    logic [W-1:0]  w_cur;
    logic [CW-1:0] w_cnt;
    logic          w_full;
    logic [W+3:0]  w_wide;
    logic [W-1:0]  w_clamp;
    logic          w_div0;

    assign w_key_fire = iKEY_VALID & oKEY_READY;
    assign w_is_digit = (iKEY_CODE < 5'd10);
    assign w_is_oper  = (iKEY_CODE >= 5'd10) && (iKEY_CODE <= 5'd13);

    // Operand currently being typed: A while in S_A, B otherwise.
    assign w_cur  = (r_state == S_B) ? r_b : r_a;
    assign w_cnt  = (r_state == S_B) ? r_cnt_b : r_cnt_a;
    assign w_full = (w_cnt >= CNT_FULL);

    // Widened so value*10 + digit cannot wrap before saturating at MAX_VAL.
    assign w_wide  = ({4'b0000, w_cur} * TEN_WIDE) + {{W{1'b0}}, iKEY_CODE[3:0]};
    assign w_clamp = (w_wide > MAX_WIDE) ? MAX_WIDE[W-1:0] : w_wide[W-1:0];
    assign w_div0  = (r_op == 2'b11) && (r_b == '0);

`ifdef KEYPAD_BACKSPACE_EN
    logic [W-1:0] w_bs;
    assign w_bs = w_cur / W'(10);
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 2'b00;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_A, S_B: begin
                    if (w_key_fire) begin
                        if (w_is_digit) begin
                            if (w_full) begin
                                r_err <= 1'b1;
                            end else if (r_state == S_A) begin
                                r_a     <= w_clamp;
                                r_cnt_a <= r_cnt_a + CW'(1);
                            end else begin
                                r_b     <= w_clamp;
                                r_cnt_b <= r_cnt_b + CW'(1);
                            end
                        end else if (w_is_oper) begin
                            r_op <= 2'(iKEY_CODE - 5'd10);
                            if (r_state == S_A) begin
                                r_b     <= '0;
                                r_cnt_b <= '0;
                                r_state <= S_B;
                            end
                        end else if (iKEY_CODE == 5'd14) begin
                            if (r_state == S_B) begin
                                if (w_div0) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_state <= S_OUT;
                                    r_valid <= 1'b1;
                                end
                            end
                        end else if (iKEY_CODE == 5'd15) begin
                            r_state <= S_A;
                            r_a     <= '0;
                            r_b     <= '0;
                            r_op    <= 2'b00;
                            r_cnt_a <= '0;
                            r_cnt_b <= '0;
                            r_valid <= 1'b0;
`ifdef KEYPAD_BACKSPACE_EN
                        end else if (iKEY_CODE == 5'd16) begin
                            // An empty operand ignores backspace silently.
                            if (w_cnt != '0) begin
                                if (r_state == S_A) begin
                                    r_a     <= w_bs;
                                    r_cnt_a <= r_cnt_a - CW'(1);
                                end else begin
                                    r_b     <= w_bs;
                                    r_cnt_b <= r_cnt_b - CW'(1);
                                end
                            end
`endif
                        end
                    end
                end
                S_OUT: begin
                    // Operands stay frozen until the result stage takes them.
                    if (iRES_READY) begin
                        r_state <= S_A;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_cnt_a <= '0;
                        r_cnt_b <= '0;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_A;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign oKEY_READY = (r_state != S_OUT);
    assign oA         = r_a;
    assign oB         = r_b;
    assign oOP        = r_op;
    assign oVALID     = r_valid;
    assign oSTATE     = r_state;
    assign oERR       = r_err;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Scoreboard bench: stimulus updates a behavioural calculator model and queues expected
// snapshots/results; an independent monitor pops and compares them on each DUT transaction.
module tb_keypad_operand_entry;

    localparam int DIG  = 2;
    localparam int MAXV = 99;
    localparam int W    = 7;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic [4:0]   key_code;
    logic         key_ready;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic [1:0]   op_out;
    logic         valid_out;
    logic         res_ready;
    logic [1:0]   state_out;
    logic         err_out;

    logic         k3_valid;
    logic [4:0]   k3_code;
    logic         k3_ready;
    logic [W-1:0] a3;
    logic [W-1:0] b3;
    logic [1:0]   op3;
    logic         valid3;
    logic [1:0]   state3;
    logic         err3;

    int errors = 0;
    int checks = 0;
    bit mon_en = 0;

    typedef struct {
        int a; int b; int op; int st; bit valid; bit ready; bit err;
    } snap_t;
    typedef struct { int a; int b; int op; } res_t;

    snap_t snap_q[$];
    res_t  res_q[$];

    // Behavioural model: calculator entry state in plain integers.
    int m_a, m_b, m_op, m_st, m_ca, m_cb;
    bit m_err;

    keypad_operand_entry #(.DIGITS(DIG), .MAX_VAL(MAXV), .W(W)) u_dut (
        .iCLK(clk), .iRST(rst), .iKEY_VALID(key_valid), .iKEY_CODE(key_code),
        .oKEY_READY(key_ready), .oA(a_out), .oB(b_out), .oOP(op_out),
        .oVALID(valid_out), .iRES_READY(res_ready), .oSTATE(state_out), .oERR(err_out)
    );

    keypad_operand_entry #(.DIGITS(3), .MAX_VAL(99), .W(7)) u_dut3 (
        .iCLK(clk), .iRST(rst), .iKEY_VALID(k3_valid), .iKEY_CODE(k3_code),
        .oKEY_READY(k3_ready), .oA(a3), .oB(b3), .oOP(op3),
        .oVALID(valid3), .iRES_READY(1'b0), .oSTATE(state3), .oERR(err3)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int min2(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_st = 0; m_ca = 0; m_cb = 0; m_err = 0;
    endtask

    task automatic model_key(input int code);
        m_err = 0;
        if (code < 10) begin
            if (m_st == 0) begin
                if (m_ca < DIG) begin m_a = min2(m_a * 10 + code, MAXV); m_ca++; end
                else m_err = 1;
            end else begin
                if (m_cb < DIG) begin m_b = min2(m_b * 10 + code, MAXV); m_cb++; end
                else m_err = 1;
            end
        end else if (code <= 13) begin
            m_op = code - 10;
            if (m_st == 0) begin m_b = 0; m_cb = 0; m_st = 1; end
        end else if (code == 14) begin
            if (m_st == 1) begin
                if (m_op == 3 && m_b == 0) m_err = 1;
                else m_st = 2;
            end
        end else if (code == 15) begin
            model_reset();
`ifdef KEYPAD_BACKSPACE_EN
        end else if (code == 16) begin
            if (m_st == 0 && m_ca > 0) begin m_a = m_a / 10; m_ca--; end
            if (m_st == 1 && m_cb > 0) begin m_b = m_b / 10; m_cb--; end
`endif
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.a = m_a; s.b = m_b; s.op = m_op; s.st = m_st;
        s.valid = (m_st == 2); s.ready = (m_st != 2); s.err = m_err;
        return s;
    endfunction

    // One clock of stimulus; expectations are queued at issue time.
    task automatic cycle(input bit kv, input int kc, input bit rr);
        bit ev;
        key_valid = kv;
        key_code  = 5'(kc);
        res_ready = rr;
        ev = 0;
        if (m_st != 2 && kv) begin
            model_key(kc);
            ev = 1;
        end else if (m_st == 2 && rr) begin
            res_t r;
            r.a = m_a; r.b = m_b; r.op = m_op;
            res_q.push_back(r);
            m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_st = 0; m_err = 0;
            ev = 1;
        end
        if (ev) snap_q.push_back(model_snap());
        @(posedge clk);
        #2;
        key_valid = 0;
        res_ready = 0;
    endtask

    task automatic key(input int code);
        cycle(1, code, 0);
    endtask

    task automatic key3(input int code);
        k3_valid = 1;
        k3_code  = 5'(code);
        @(posedge clk);
        #2;
        k3_valid = 0;
    endtask

    // Monitor: at each falling edge, verify the outcome of the previous edge's transaction.
    bit pend = 0;
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            pend = 0;
        end else begin
            if (pend) begin
                if (snap_q.size() == 0) begin
                    chk("unexpected_transaction", 1, 0);
                end else begin
                    snap_t s;
                    s = snap_q.pop_front();
                    checks++;
                    if (a_out != W'(s.a) || b_out != W'(s.b) || op_out != 2'(s.op) ||
                        state_out != 2'(s.st) || valid_out != s.valid ||
                        key_ready != s.ready || err_out != s.err) begin
                        errors++;
                        $display("FAIL snapshot: got A=%0d B=%0d OP=%0d ST=%0d V=%0b R=%0b E=%0b expected A=%0d B=%0d OP=%0d ST=%0d V=%0b R=%0b E=%0b",
                                 a_out, b_out, op_out, state_out, valid_out, key_ready, err_out,
                                 s.a, s.b, s.op, s.st, s.valid, s.ready, s.err);
                    end
                end
            end else begin
                chk("err_idle", int'(err_out), 0);
            end
            pend = (key_valid & key_ready) | (valid_out & res_ready);
            if (valid_out & res_ready) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    checks++;
                    if (a_out != W'(r.a) || b_out != W'(r.b) || op_out != 2'(r.op)) begin
                        errors++;
                        $display("FAIL result: got A=%0d B=%0d OP=%0d expected A=%0d B=%0d OP=%0d",
                                 a_out, b_out, op_out, r.a, r.b, r.op);
                    end else begin
                        $display("result A=%0d B=%0d OP=%0d", a_out, b_out, op_out);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1; key_valid = 0; key_code = 0; res_ready = 0; k3_valid = 0; k3_code = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_state", int'(state_out), 0);
        chk("rst_a", int'(a_out), 0);
        chk("rst_b", int'(b_out), 0);
        chk("rst_op", int'(op_out), 0);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_ready", int'(key_ready), 1);
        chk("rst_err", int'(err_out), 0);
        rst = 0;
        mon_en = 1;

        // 42 + 7 = with downstream stalled, then released.
        key(4); key(2); key(10); key(7); key(14);
        cycle(0, 0, 0); cycle(0, 0, 0);
        chk("t1_a", int'(a_out), 42);
        chk("t1_b", int'(b_out), 7);
        chk("t1_op", int'(op_out), 0);
        chk("t1_state", int'(state_out), 2);
        chk("t1_valid", int'(valid_out), 1);
        chk("t1_ready", int'(key_ready), 0);
        cycle(1, 9, 0);
        chk("t1_hold_a", int'(a_out), 42);
        cycle(0, 0, 1);
        chk("t1_post_state", int'(state_out), 0);
        chk("t1_post_a", int'(a_out), 0);
        chk("t1_post_valid", int'(valid_out), 0);
        chk("t1_post_ready", int'(key_ready), 1);

        // Digit overflow.
        key(1); key(2);
        chk("t2_a", int'(a_out), 12);
        key(3);
        chk("t2_err", int'(err_out), 1);
        chk("t2_a_hold", int'(a_out), 12);
        cycle(0, 0, 0);
        chk("t2_err_pulse", int'(err_out), 0);
        key(15);

        // Divide by zero refused, then corrected.
        key(8); key(13); key(0); key(14);
        chk("t4_err", int'(err_out), 1);
        chk("t4_state", int'(state_out), 1);
        chk("t4_valid", int'(valid_out), 0);
        key(2); key(14);
        chk("t4_b", int'(b_out), 2);
        chk("t4_op", int'(op_out), 3);
        chk("t4_valid2", int'(valid_out), 1);
        cycle(0, 0, 1);

        // Clear mid-entry.
        key(5); key(12); key(3); key(15);
        chk("t5_a", int'(a_out), 0);
        chk("t5_b", int'(b_out), 0);
        chk("t5_op", int'(op_out), 0);
        chk("t5_state", int'(state_out), 0);

        // Backspace / reserved code 16.
        key(4); key(2); key(16);
`ifdef KEYPAD_BACKSPACE_EN
        chk("t6_bs_a", int'(a_out), 4);
        key(7);
        chk("t6_bs_a2", int'(a_out), 47);
`else
        chk("t6_res_a", int'(a_out), 42);
        chk("t6_res_err", int'(err_out), 0);
`endif
        key(20);
        key(15);

        // Three-digit instance: saturation without wrap.
        key3(1); key3(5); key3(0);
        chk("t3_a_clamp", int'(a3), 99);
        key3(4);
        chk("t3_err", int'(err3), 1);
        chk("t3_a_hold", int'(a3), 99);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            int code;
            bit kv;
            bit rr;
            kv = ($urandom % 4) != 0;
            code = (($urandom % 10) < 6) ? int'($urandom % 10) : int'($urandom_range(10, 31));
            rr = ($urandom % 3) == 0;
            cycle(kv, code, rr);
        end

        // Async reset while a result is pending.
        if (m_st == 2) cycle(0, 0, 1);
        key(15); key(1); key(10); key(2); key(14);
        chk("t5_pre_valid", int'(valid_out), 1);
        @(negedge clk);
        #1;
        mon_en = 0;
        rst = 1;
        #1;
        chk("t5_async_valid", int'(valid_out), 0);
        chk("t5_async_state", int'(state_out), 0);
        chk("t5_async_a", int'(a_out), 0);
        chk("snap_q_drained", snap_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);
        @(posedge clk);
        #2;
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
